// File: rtl/data_mem_mmio.sv
// data_mem_mmio
// Data memory plus memory-mapped peripherals for the MEM stage of the pipeline CPU.
// Reads are combinational. Every write commits on the rising edge of clk.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   addr       byte address; the word index is addr[31:2]
//   WriteData  store data, already lane-aligned
//   MemRead    read strobe; ReadData is zero while it is low
//   MemWrite   write strobe
//   ByteEn     per-lane write enables for the RAM
//   ReadData   combinational read data
//   leds       LED register
//   AN         seven-segment digit anodes, active-low
//   BCD        seven-segment pattern {dp,g,f,e,d,c,b,a}, active-low
//   irq        timer interrupt status (TCON[2])
//
// MMIO map, word aligned:
//   0x40000000 TH, 0x40000004 TL, 0x40000008 TCON, 0x4000000C LED,
//   0x40000010 DIGI, 0x40000014 SYSTICK.
// An MMIO register is written only by a full-word store (ByteEn = 4'hF).
module data_mem_mmio #(
    parameter int MEM_WORDS = 512,
    parameter int SCAN_DIV  = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [31:0] WriteData,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [3:0]  ByteEn,
    output logic [31:0] ReadData,
    output logic [7:0]  leds,
    output logic [3:0]  AN,
    output logic [7:0]  BCD,
    output logic        irq
);

    localparam int AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_DIV - 1);
    localparam logic [29:0] RAM_LIMIT   = 30'(MEM_WORDS);

    localparam logic [29:0] TH_IDX      = 30'h1000_0000;
    localparam logic [29:0] TL_IDX      = 30'h1000_0001;
    localparam logic [29:0] TCON_IDX    = 30'h1000_0002;
    localparam logic [29:0] LED_IDX     = 30'h1000_0003;
    localparam logic [29:0] DIGI_IDX    = 30'h1000_0004;
    localparam logic [29:0] SYSTICK_IDX = 30'h1000_0005;

    logic [29:0]   word_idx;
    logic [AW-1:0] ram_idx;
    logic          ram_hit;
    logic          mmio_we;
    logic          unused_addr_bits;

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic        tl_max;
    logic        irq_set;
    logic [31:0] systick;

    logic           disp_auto;
    logic [3:0]     raw_an;
    logic [7:0]     raw_bcd;
    logic [15:0]    disp_val;
    logic [1:0]     disp_idx;
    logic [SCW-1:0] scan_cnt;
    logic [31:0]    digi_rd;

    // Byte addresses drop their lane bits. Only full-word stores reach MMIO registers.
    assign word_idx         = addr[31:2];
    assign ram_idx          = word_idx[AW-1:0];
    assign ram_hit          = (word_idx < RAM_LIMIT);
    assign mmio_we          = MemWrite && (ByteEn == 4'hF);
    assign unused_addr_bits = ^addr[1:0];

    // Hex digit to active-low segment pattern. Bit 7 (dp) stays high, so the dot is off.
    function automatic logic [7:0] seg(input logic [3:0] nib);
        logic [7:0] code;
        case (nib)
            4'h0:    code = 8'hC0;
            4'h1:    code = 8'hF9;
            4'h2:    code = 8'hA4;
            4'h3:    code = 8'hB0;
            4'h4:    code = 8'h99;
            4'h5:    code = 8'h92;
            4'h6:    code = 8'h82;
            4'h7:    code = 8'hF8;
            4'h8:    code = 8'h80;
            4'h9:    code = 8'h90;
            4'hA:    code = 8'h88;
            4'hB:    code = 8'h83;
            4'hC:    code = 8'hC6;
            4'hD:    code = 8'hA1;
            4'hE:    code = 8'h86;
            default: code = 8'h8E;
        endcase
        return code;
    endfunction

    // Word RAM with per-lane writes. Reset leaves the contents alone but blocks
    // stores during the reset cycle, so reset wins over a write in that cycle.
    always_ff @(posedge clk) begin
        if (!reset && MemWrite && ram_hit) begin
            for (int k = 0; k < 4; k++) begin
                if (ByteEn[k]) begin
                    mem[ram_idx][8*k +: 8] <= WriteData[8*k +: 8];
                end
            end
        end
    end

    // Free-running cycle counter. Software cannot write it.
    always_ff @(posedge clk) begin
        if (reset) begin
            systick <= 32'h0;
        end else begin
            systick <= systick + 32'd1;
        end
    end

    // LED register.
    always_ff @(posedge clk) begin
        if (reset) begin
            leds <= 8'h00;
        end else if (mmio_we && (word_idx == LED_IDX)) begin
            leds <= WriteData[7:0];
        end
    end

    // Reload timer. A bus write to TL takes priority over counting.
    // A hardware overflow is ORed into the status bit, so a clear written in
    // the same cycle cannot drop an interrupt.
    assign tl_max  = (tl == 32'hFFFF_FFFF);
    assign irq_set = tcon[0] && tcon[1] && tl_max;

    always_ff @(posedge clk) begin
        if (reset) begin
            th   <= 32'h0;
            tl   <= 32'h0;
            tcon <= 3'b000;
        end else begin
            if (mmio_we && (word_idx == TH_IDX)) begin
                th <= WriteData;
            end
            if (mmio_we && (word_idx == TL_IDX)) begin
                tl <= WriteData;
            end else if (tcon[0]) begin
                tl <= tl_max ? th : tl + 32'd1;
            end
            if (mmio_we && (word_idx == TCON_IDX)) begin
                tcon <= {WriteData[2] | irq_set, WriteData[1:0]};
            end else if (irq_set) begin
                tcon[2] <= 1'b1;
            end
        end
    end

    assign irq = tcon[2];

    // Display port. Raw mode latches AN and BCD directly. Auto mode stores a
    // 16-bit value and walks the four digits, holding each for SCAN_DIV cycles.
    // A new auto-mode write restarts the scan at digit 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            disp_auto <= 1'b0;
            raw_an    <= 4'hF;
            raw_bcd   <= 8'hFF;
            disp_val  <= 16'h0;
            disp_idx  <= 2'd0;
            scan_cnt  <= '0;
        end else if (mmio_we && (word_idx == DIGI_IDX)) begin
            if (WriteData[31]) begin
                disp_auto <= 1'b1;
                disp_val  <= WriteData[15:0];
                disp_idx  <= 2'd0;
                scan_cnt  <= '0;
            end else begin
                disp_auto <= 1'b0;
                raw_an    <= WriteData[11:8];
                raw_bcd   <= WriteData[7:0];
            end
        end else if (disp_auto) begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                disp_idx <= disp_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    assign AN      = disp_auto ? ~(4'b0001 << disp_idx) : raw_an;
    assign BCD     = disp_auto ? seg(disp_val[{disp_idx, 2'b00} +: 4]) : raw_bcd;
    assign digi_rd = disp_auto ? {1'b1, 15'h0, disp_val} : {20'h0, raw_an, raw_bcd};

    // Read mux. It uses pre-edge state, so a load and a store to the same
    // location in one cycle return the old value.
    always_comb begin
        ReadData = 32'h0;
        if (MemRead) begin
            if (ram_hit) begin
                ReadData = mem[ram_idx];
            end else begin
                case (word_idx)
                    TH_IDX:      ReadData = th;
                    TL_IDX:      ReadData = tl;
                    TCON_IDX:    ReadData = {29'h0, tcon};
                    LED_IDX:     ReadData = {24'h0, leds};
                    DIGI_IDX:    ReadData = digi_rd;
                    SYSTICK_IDX: ReadData = systick;
                    default:     ReadData = 32'h0;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_data_mem_mmio.sv
// tb_data_mem_mmio
// Directed bench for data_mem_mmio with SCAN_DIV = 4.
// Single-cycle behaviour comes from a vector table. Timer, auto-scan and reset
// sequences are written out cycle by cycle.
// Inputs are driven on the falling edge. Outputs are sampled 1 ns later,
// before the next rising edge commits the cycle.
module tb_data_mem_mmio;

    localparam int MEM_WORDS = 512;
    localparam int SCAN_DIV  = 4;

    localparam logic [31:0] A_TH      = 32'h4000_0000;
    localparam logic [31:0] A_TL      = 32'h4000_0004;
    localparam logic [31:0] A_TCON    = 32'h4000_0008;
    localparam logic [31:0] A_LED     = 32'h4000_000C;
    localparam logic [31:0] A_DIGI    = 32'h4000_0010;
    localparam logic [31:0] A_SYSTICK = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] addr = 32'h0;
    logic [31:0] WriteData = 32'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [3:0]  ByteEn = 4'h0;
    logic [31:0] ReadData;
    logic [7:0]  leds;
    logic [3:0]  AN;
    logic [7:0]  BCD;
    logic        irq;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        rd_en;
        logic        wr_en;
        logic [3:0]  be;
        logic [31:0] exp_rd;
        logic [7:0]  exp_leds;
        logic [3:0]  exp_an;
        logic [7:0]  exp_bcd;
        string       name;
    } vec_t;

    vec_t vecs[$];

    logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [15:0] digi_val = 16'h1234;

    data_mem_mmio #(
        .MEM_WORDS(MEM_WORDS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .WriteData(WriteData),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .ByteEn   (ByteEn),
        .ReadData (ReadData),
        .leds     (leds),
        .AN       (AN),
        .BCD      (BCD),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One bus cycle. Inputs are set on the falling edge and settle before sampling.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic r, input logic w, input logic [3:0] be);
        @(negedge clk);
        addr      = a;
        WriteData = d;
        MemRead   = r;
        MemWrite  = w;
        ByteEn    = be;
        #1;
    endtask

    task automatic add_vec(input logic [31:0] a, input logic [31:0] d, input logic r,
                           input logic w, input logic [3:0] be, input logic [31:0] erd,
                           input logic [7:0] eld, input logic [3:0] ean,
                           input logic [7:0] ebcd, input string nm);
        vec_t v;
        v.addr = a; v.wdata = d; v.rd_en = r; v.wr_en = w; v.be = be;
        v.exp_rd = erd; v.exp_leds = eld; v.exp_an = ean; v.exp_bcd = ebcd; v.name = nm;
        vecs.push_back(v);
    endtask

    // One reset cycle with a full LED store applied at the same time. Returns in
    // the first cycle after reset, with SYSTICK on the read port.
    task automatic reset_pulse();
        @(negedge clk);
        reset     = 1'b1;
        addr      = A_LED;
        WriteData = 32'h0000_00AA;
        MemRead   = 1'b0;
        MemWrite  = 1'b1;
        ByteEn    = 4'hF;
        @(negedge clk);
        reset     = 1'b0;
        addr      = A_SYSTICK;
        WriteData = 32'h0;
        MemRead   = 1'b1;
        MemWrite  = 1'b0;
        ByteEn    = 4'h0;
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        checkOutput({tag, "_irq"},     32'(irq),  32'h0);
        checkOutput({tag, "_an"},      32'(AN),   32'hF);
        checkOutput({tag, "_bcd"},     32'(BCD),  32'hFF);
        checkOutput({tag, "_leds"},    32'(leds), 32'h0);
        checkOutput({tag, "_systick"}, ReadData,  32'h0);
    endtask

    initial begin
        logic [3:0] exp_an;
        logic [7:0] exp_bcd;
        int         d;

        // Single-cycle vectors. Expected ReadData is the pre-edge value.
        add_vec(32'h0,      32'h1122_3344, 1'b0, 1'b1, 4'hF, 32'h0,         8'h00, 4'hF, 8'hFF, "ram_wr_full");
        add_vec(32'h0,      32'hAABB_CCDD, 1'b1, 1'b1, 4'h5, 32'h1122_3344, 8'h00, 4'hF, 8'hFF, "ram_rd_before_wr");
        add_vec(32'h0,      32'h0,         1'b1, 1'b0, 4'h0, 32'h11BB_33DD, 8'h00, 4'hF, 8'hFF, "ram_byte_en");
        add_vec(32'h0,      32'h0,         1'b0, 1'b0, 4'h0, 32'h0,         8'h00, 4'hF, 8'hFF, "ram_no_read");
        add_vec(32'h3,      32'h0,         1'b1, 1'b0, 4'h0, 32'h11BB_33DD, 8'h00, 4'hF, 8'hFF, "ram_low_bits");
        add_vec(32'h4,      32'hCAFE_F00D, 1'b0, 1'b1, 4'hF, 32'h0,         8'h00, 4'hF, 8'hFF, "ram_wr_w1");
        add_vec(32'h4,      32'h0000_0077, 1'b1, 1'b1, 4'h8, 32'hCAFE_F00D, 8'h00, 4'hF, 8'hFF, "ram_wr_lane3");
        add_vec(32'h4,      32'h0,         1'b1, 1'b0, 4'h0, 32'h00FE_F00D, 8'h00, 4'hF, 8'hFF, "ram_lane3");
        add_vec(32'h7FC,    32'h1357_9BDF, 1'b0, 1'b1, 4'hF, 32'h0,         8'h00, 4'hF, 8'hFF, "ram_wr_last");
        add_vec(32'h7FC,    32'h0,         1'b1, 1'b0, 4'h0, 32'h1357_9BDF, 8'h00, 4'hF, 8'hFF, "ram_last_word");
        add_vec(32'h800,    32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF, 32'h0,         8'h00, 4'hF, 8'hFF, "ram_wr_oob");
        add_vec(32'h800,    32'h0,         1'b1, 1'b0, 4'h0, 32'h0,         8'h00, 4'hF, 8'hFF, "ram_oob_read");
        add_vec(32'h0,      32'h0,         1'b1, 1'b0, 4'h0, 32'h11BB_33DD, 8'h00, 4'hF, 8'hFF, "ram_no_alias");
        add_vec(A_LED,      32'h0000_005A, 1'b0, 1'b1, 4'hF, 32'h0,         8'h00, 4'hF, 8'hFF, "led_wr");
        add_vec(A_LED,      32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_005A, 8'h5A, 4'hF, 8'hFF, "led_rd");
        add_vec(A_LED,      32'h0000_00FF, 1'b1, 1'b1, 4'h1, 32'h0000_005A, 8'h5A, 4'hF, 8'hFF, "led_partial_wr");
        add_vec(A_LED,      32'h0000_00FF, 1'b1, 1'b0, 4'hF, 32'h0000_005A, 8'h5A, 4'hF, 8'hFF, "led_no_memwrite");
        add_vec(A_LED,      32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_005A, 8'h5A, 4'hF, 8'hFF, "led_held");
        add_vec(32'h4000_0020, 32'h1234_5678, 1'b0, 1'b1, 4'hF, 32'h0,      8'h5A, 4'hF, 8'hFF, "unmapped_wr");
        add_vec(32'h4000_0020, 32'h0,      1'b1, 1'b0, 4'h0, 32'h0,         8'h5A, 4'hF, 8'hFF, "unmapped_rd");
        add_vec(A_TH,       32'h1234_5678, 1'b0, 1'b1, 4'hF, 32'h0,         8'h5A, 4'hF, 8'hFF, "th_wr");
        add_vec(A_TH,       32'h0,         1'b1, 1'b0, 4'h0, 32'h1234_5678, 8'h5A, 4'hF, 8'hFF, "th_rd");
        add_vec(A_TL,       32'hDEAD_BEEF, 1'b0, 1'b1, 4'hF, 32'h0,         8'h5A, 4'hF, 8'hFF, "tl_wr");
        add_vec(A_TL,       32'h0,         1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF, 8'h5A, 4'hF, 8'hFF, "tl_rd");
        add_vec(A_TL,       32'h0,         1'b1, 1'b0, 4'h0, 32'hDEAD_BEEF, 8'h5A, 4'hF, 8'hFF, "tl_hold_off");
        add_vec(A_TCON,     32'h0000_0007, 1'b0, 1'b1, 4'h7, 32'h0,         8'h5A, 4'hF, 8'hFF, "tcon_partial_wr");
        add_vec(A_TCON,     32'h0,         1'b1, 1'b0, 4'h0, 32'h0,         8'h5A, 4'hF, 8'hFF, "tcon_partial");
        add_vec(A_DIGI,     32'h0000_0E92, 1'b1, 1'b1, 4'hF, 32'h0000_0FFF, 8'h5A, 4'hF, 8'hFF, "digi_raw_wr");
        add_vec(A_DIGI,     32'h0,         1'b1, 1'b0, 4'h0, 32'h0000_0E92, 8'h5A, 4'hE, 8'h92, "digi_raw_rd");
        add_vec(32'h0,      32'h0,         1'b1, 1'b0, 4'h0, 32'h11BB_33DD, 8'h5A, 4'hE, 8'h92, "ram_after_mmio");

        // Power-up reset.
        reset_pulse();
        check_reset_state("por");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].rd_en, vecs[i].wr_en, vecs[i].be);
            checkOutput({vecs[i].name, "_rd"},   ReadData,  vecs[i].exp_rd);
            checkOutput({vecs[i].name, "_leds"}, 32'(leds), 32'(vecs[i].exp_leds));
            checkOutput({vecs[i].name, "_an"},   32'(AN),   32'(vecs[i].exp_an));
            checkOutput({vecs[i].name, "_bcd"},  32'(BCD),  32'(vecs[i].exp_bcd));
        end

        // Timer: reload, irq, the collision between set and clear, masked irq,
        // TL write priority, and hold while disabled.
        applyStimulus(A_TH,   32'hFFFF_FFFD, 1'b0, 1'b1, 4'hF);
        applyStimulus(A_TL,   32'hFFFF_FFFE, 1'b0, 1'b1, 4'hF);
        applyStimulus(A_TCON, 32'h0000_0003, 1'b0, 1'b1, 4'hF);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_start", ReadData, 32'hFFFF_FFFE);
        checkOutput("irq_low0", 32'(irq), 32'h0);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_plus1", ReadData, 32'hFFFF_FFFF);
        checkOutput("irq_low1", 32'(irq), 32'h0);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_reload", ReadData, 32'hFFFF_FFFD);
        checkOutput("irq_rise", 32'(irq), 32'h1);
        applyStimulus(A_TCON, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tcon_irq", ReadData, 32'h7);
        applyStimulus(A_TCON, 32'h0000_0003, 1'b1, 1'b1, 4'hF);
        checkOutput("tcon_pre_collision", ReadData, 32'h7);
        applyStimulus(A_TCON, 32'h0000_0003, 1'b1, 1'b1, 4'hF);
        checkOutput("tcon_collision", ReadData, 32'h7);
        checkOutput("irq_kept", 32'(irq), 32'h1);
        applyStimulus(A_TCON, 32'h0000_0001, 1'b1, 1'b1, 4'hF);
        checkOutput("tcon_cleared", ReadData, 32'h3);
        checkOutput("irq_cleared", 32'(irq), 32'h0);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_pre_masked", ReadData, 32'hFFFF_FFFF);
        applyStimulus(A_TL, 32'h0000_0100, 1'b1, 1'b1, 4'hF);
        checkOutput("tl_masked_reload", ReadData, 32'hFFFF_FFFD);
        checkOutput("irq_masked", 32'(irq), 32'h0);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_write_priority", ReadData, 32'h0000_0100);
        applyStimulus(A_TCON, 32'h0, 1'b1, 1'b1, 4'hF);
        checkOutput("tcon_masked", ReadData, 32'h1);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_last_count", ReadData, 32'h0000_0102);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("tl_disabled_hold", ReadData, 32'h0000_0102);

        // Auto-scan: each digit is held for SCAN_DIV cycles, least significant first.
        applyStimulus(A_DIGI, 32'h8000_1234, 1'b0, 1'b1, 4'hF);
        for (int cyc = 1; cyc <= 5 * SCAN_DIV; cyc++) begin
            applyStimulus(A_DIGI, 32'h0, 1'b1, 1'b0, 4'h0);
            d = ((cyc - 1) / SCAN_DIV) % 4;
            exp_an = 4'hF;
            exp_an[d] = 1'b0;
            exp_bcd = seg_tab[digi_val[4*d +: 4]];
            checkOutput($sformatf("scan_an_c%0d", cyc), 32'(AN), 32'(exp_an));
            checkOutput($sformatf("scan_bcd_c%0d", cyc), 32'(BCD), 32'(exp_bcd));
            checkOutput($sformatf("scan_rd_c%0d", cyc), ReadData, 32'h8000_1234);
        end

        // Reset in the middle of operation: timer running with irq set, scan
        // active, and leds = 0xFF.
        applyStimulus(A_LED,  32'h0000_00FF, 1'b0, 1'b1, 4'hF);
        applyStimulus(A_TL,   32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF);
        applyStimulus(A_TCON, 32'h0000_0003, 1'b0, 1'b1, 4'hF);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("pre_rst_tl", ReadData, 32'hFFFF_FFFF);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("pre_rst_reload", ReadData, 32'hFFFF_FFFD);
        checkOutput("pre_rst_irq", 32'(irq), 32'h1);
        checkOutput("pre_rst_leds", 32'(leds), 32'hFF);
        reset_pulse();
        check_reset_state("mid_rst");
        applyStimulus(A_SYSTICK, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("systick_1", ReadData, 32'h1);
        applyStimulus(A_SYSTICK, 32'h0, 1'b1, 1'b1, 4'hF);
        checkOutput("systick_2", ReadData, 32'h2);
        applyStimulus(A_SYSTICK, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("systick_wr_ignored", ReadData, 32'h3);
        applyStimulus(A_TL, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_tl", ReadData, 32'h0);
        applyStimulus(A_TH, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_th", ReadData, 32'h0);
        applyStimulus(A_TCON, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_tcon", ReadData, 32'h0);
        applyStimulus(A_DIGI, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_digi", ReadData, 32'h0000_0FFF);
        applyStimulus(A_LED, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_led", ReadData, 32'h0);
        applyStimulus(32'h0, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_ram_kept", ReadData, 32'h11BB_33DD);
        applyStimulus(32'h7FC, 32'h0, 1'b1, 1'b0, 4'h0);
        checkOutput("rst_ram_last_kept", ReadData, 32'h1357_9BDF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
